// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencer between an issue port, an external ALU and the register file
//
// Purpose: accepts one operation at a time, drives the ALU with the latched
// operands for the opcode's latency, captures the results and flags, then
// writes back one or two registers and strobes the flag register.
//
// Ports:
//   clk, reset (async, active-low)
//   issue_*          : request handshake and operation fields
//   flush            : abort of an operation still in EXEC
//   alu_*  (out)     : held operation fields and ALU enable
//   alu_result_0/1,
//   alu_next_flags   : ALU outputs, sampled on the last EXEC cycle
//   wb_en/addr/data  : single register-file write port
//   flag_reg_en      : flag register load strobe
//   flag_data        : flags captured from the ALU, loaded on flag_reg_en
//   busy             : high whenever the sequencer is not IDLE
module alu_seq_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_opcode,
  input  logic [2:0]  issue_rd,
  input  logic [15:0] issue_op1,
  input  logic [15:0] issue_op2,
  input  logic [3:0]  issue_bitpos,
  input  logic [7:0]  issue_imm,
  input  logic        flush,
  output logic        alu_en,
  output logic [4:0]  alu_opcode,
  output logic [15:0] alu_operand_1,
  output logic [15:0] alu_operand_2,
  output logic [3:0]  alu_bit_position,
  output logic [7:0]  alu_immediate,
  output logic [2:0]  alu_rd,
  input  logic [15:0] alu_result_0,
  input  logic [15:0] alu_result_1,
  input  logic [15:0] alu_next_flags,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        flag_reg_en,
  output logic [15:0] flag_data,
  output logic        busy
);

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_RR   = 5'd11;
  localparam logic [4:0] OP_RL   = 5'd12;
  localparam logic [4:0] OP_SETB = 5'd13;
  localparam logic [4:0] OP_CLRB = 5'd14;
  localparam logic [4:0] OP_CPLB = 5'd15;
  localparam logic [4:0] OP_SETF = 5'd16;
  localparam logic [4:0] OP_CLRF = 5'd17;
  localparam logic [4:0] OP_CPLF = 5'd18;
  localparam logic [4:0] OP_LBL  = 5'd19;
  localparam logic [4:0] OP_LBH  = 5'd20;
  localparam logic [4:0] OP_MOV  = 5'd21;

  typedef enum logic [1:0] {IDLE, EXEC, WB0, WB1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  lat_m1;
  logic [4:0]  opc;
  logic [2:0]  rd;
  logic [15:0] op1, op2;
  logic [3:0]  bitpos;
  logic [7:0]  imm;
  logic [15:0] res0, res1, flg;
  logic        accept;
  logic        is_alu, is_move, no_wb, two_wb;

  // issue_ready is gated by reset so nothing is offered while reset is held.
  assign issue_ready = (state == IDLE) && reset;
  assign accept      = issue_valid && issue_ready;
  assign busy        = (state != IDLE);

  assign alu_en           = (state == EXEC) && is_alu;
  assign alu_opcode       = opc;
  assign alu_operand_1    = op1;
  assign alu_operand_2    = op2;
  assign alu_bit_position = bitpos;
  assign alu_immediate    = imm;
  assign alu_rd           = rd;
  assign flag_data        = flg;

  // EXEC length is chosen from the incoming opcode so cnt is loaded on accept.
  always_comb begin
    lat_m1 = 4'd0;
    case (issue_opcode)
      OP_MUL:  lat_m1 = 4'(MUL_LAT - 1);
      OP_DIV:  lat_m1 = 4'(DIV_LAT - 1);
      default: lat_m1 = 4'd0;
    endcase
  end

  // Class of the latched opcode; anything unlisted behaves as a NOP.
  always_comb begin
    is_alu  = 1'b0;
    is_move = 1'b0;
    no_wb   = 1'b0;
    two_wb  = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC,
      OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB: is_alu = 1'b1;
      OP_MUL, OP_DIV: begin
        is_alu = 1'b1;
        two_wb = 1'b1;
      end
      OP_CMP, OP_SETF, OP_CLRF, OP_CPLF: begin
        is_alu = 1'b1;
        no_wb  = 1'b1;
      end
      OP_LBL, OP_LBH, OP_MOV: is_move = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wb_en       = 1'b0;
    wb_addr     = 3'd0;
    wb_data     = 16'd0;
    flag_reg_en = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = (is_alu || is_move) ? WB0 : IDLE;
        end
      end
      WB0: begin
        wb_en       = !no_wb;
        wb_addr     = rd;
        wb_data     = res0;
        flag_reg_en = is_alu;
        state_nxt   = two_wb ? WB1 : IDLE;
      end
      WB1: begin
        wb_en     = 1'b1;
        wb_addr   = rd + 3'd1;
        wb_data   = res1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      opc    <= 5'd0;
      rd     <= 3'd0;
      op1    <= 16'd0;
      op2    <= 16'd0;
      bitpos <= 4'd0;
      imm    <= 8'd0;
      res0   <= 16'd0;
      res1   <= 16'd0;
      flg    <= 16'd0;
    end else if (accept) begin
      cnt    <= lat_m1;
      opc    <= issue_opcode;
      rd     <= issue_rd;
      op1    <= issue_op1;
      op2    <= issue_op2;
      bitpos <= issue_bitpos;
      imm    <= issue_imm;
    end else if (state == EXEC && !flush) begin
      if (cnt == 4'd0) begin
        res0 <= alu_result_0;
        res1 <= alu_result_1;
        flg  <= alu_next_flags;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_RL   = 5'd12;
  localparam logic [4:0] OP_SETB = 5'd13;
  localparam logic [4:0] OP_SETF = 5'd16;
  localparam logic [4:0] OP_CPLF = 5'd18;
  localparam logic [4:0] OP_LBL  = 5'd19;
  localparam logic [4:0] OP_LBH  = 5'd20;
  localparam logic [4:0] OP_MOV  = 5'd21;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic        clk, reset, issue_valid, issue_ready, flush;
  logic [4:0]  issue_opcode, alu_opcode;
  logic [2:0]  issue_rd, alu_rd, wb_addr;
  logic [15:0] issue_op1, issue_op2, alu_operand_1, alu_operand_2;
  logic [3:0]  issue_bitpos, alu_bit_position;
  logic [7:0]  issue_imm, alu_immediate;
  logic        alu_en, wb_en, flag_reg_en, busy;
  logic [15:0] alu_result_0, alu_result_1, alu_next_flags, wb_data, flag_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_wb[$];
  logic [15:0] exp_flg[$];
  logic [2:0]  last_wb_addr;
  logic [15:0] last_wb_data;
  logic [15:0] last_flag_data;

  alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_rd(issue_rd),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_bitpos(issue_bitpos), .issue_imm(issue_imm),
    .flush(flush),
    .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_bit_position(alu_bit_position), .alu_immediate(alu_immediate),
    .alu_rd(alu_rd),
    .alu_result_0(alu_result_0), .alu_result_1(alu_result_1),
    .alu_next_flags(alu_next_flags),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_reg_en(flag_reg_en), .flag_data(flag_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {result_0, result_1, flags}; flags bit3 = operands equal.
  function automatic logic [47:0] alu_model(input logic [4:0] opc, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] bp,
                                            input logic [7:0] im);
    logic [15:0] r0, r1;
    logic [16:0] s;
    logic [31:0] p;
    logic        c;
    r0 = 16'd0; r1 = 16'd0; c = 1'b0;
    s = 17'd0; p = 32'd0;
    case (opc)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r0 = s[15:0]; c = s[16]; end
      OP_SUB:  r0 = a - b;
      OP_MUL:  begin p = {16'd0, a} * {16'd0, b}; r0 = p[15:0]; r1 = p[31:16]; end
      OP_DIV:  if (b == 16'd0) begin r0 = 16'hFFFF; r1 = a; end
               else begin r0 = a / b; r1 = a % b; end
      OP_XOR:  r0 = a ^ b;
      OP_INC:  r0 = a + 16'd1;
      OP_CMP:  r0 = a - b;
      OP_RL:   r0 = {a[14:0], a[15]};
      OP_SETB: r0 = a | (16'd1 << bp);
      OP_LBL:  r0 = {a[15:8], im};
      OP_LBH:  r0 = {im, a[7:0]};
      OP_MOV:  r0 = a;
      default: r0 = 16'd0;
    endcase
    return {r0, r1, 12'd0, (a == b), r0[15], c, (r0 == 16'd0)};
  endfunction

  assign {alu_result_0, alu_result_1, alu_next_flags} =
    alu_model(alu_opcode, alu_operand_1, alu_operand_2, alu_bit_position, alu_immediate);

  function automatic bit is_alu_op(input logic [4:0] o);
    return (o >= 5'd1 && o <= 5'd18);
  endfunction
  function automatic bit is_move_op(input logic [4:0] o);
    return (o == OP_LBL || o == OP_LBH || o == OP_MOV);
  endfunction
  function automatic bit no_wb_op(input logic [4:0] o);
    return (o == OP_CMP || o == OP_SETF || o == 5'd17 || o == OP_CPLF);
  endfunction

  // Scoreboard: every register write and flag load must match the head of its queue.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      n_checks++;
      if (exp_wb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: addr=%0d data=%h, required no write", wb_addr, wb_data);
      end else begin
        logic [18:0] e;
        e = exp_wb.pop_front();
        if ({wb_addr, wb_data} !== e) begin
          n_fail++;
          $display("FAIL wb_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wb_addr, wb_data, e[18:16], e[15:0]);
        end
      end
      last_wb_addr = wb_addr;
      last_wb_data = wb_data;
    end
    if (flag_reg_en === 1'b1) begin
      n_checks++;
      if (exp_flg.size() == 0) begin
        n_fail++;
        $display("FAIL flag_unexpected: flag_data=%h, required no flag load", flag_data);
      end else begin
        logic [15:0] f;
        f = exp_flg.pop_front();
        if (flag_data !== f) begin
          n_fail++;
          $display("FAIL flag_data: got %h expected %h", flag_data, f);
        end
      end
      last_flag_data = flag_data;
    end
  end

  task automatic push_expect(input logic [4:0] opc, input logic [2:0] rd, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] bp, input logic [7:0] im);
    logic [47:0] m;
    m = alu_model(opc, a, b, bp, im);
    if ((is_alu_op(opc) || is_move_op(opc)) && !no_wb_op(opc)) exp_wb.push_back({rd, m[47:32]});
    if (opc == OP_MUL || opc == OP_DIV) exp_wb.push_back({rd + 3'd1, m[31:16]});
    if (is_alu_op(opc)) exp_flg.push_back(m[15:0]);
  endtask

  task automatic drive_issue(input logic [4:0] opc, input logic [2:0] rd, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] bp, input logic [7:0] im);
    issue_valid = 1'b1; issue_opcode = opc; issue_rd = rd;
    issue_op1 = a; issue_op2 = b; issue_bitpos = bp; issue_imm = im;
  endtask

  // Issues one op from IDLE and measures it until busy drops.
  task automatic run_op(input logic [4:0] opc, input logic [2:0] rd, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] bp, input logic [7:0] im,
                        output int busy_c, output int alu_c, output int wb_c, output int flg_c);
    bit stable;
    busy_c = 0; alu_c = 0; wb_c = 0; flg_c = 0; stable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: issue_ready=%b required 1", issue_ready);
    end
    drive_issue(opc, rd, a, b, bp, im);
    push_expect(opc, rd, a, b, bp, im);
    @(negedge clk);
    issue_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      busy_c++;
      if (alu_en === 1'b1) alu_c++;
      if (wb_en === 1'b1) wb_c++;
      if (flag_reg_en === 1'b1) flg_c++;
      if (alu_opcode !== opc || alu_operand_1 !== a || alu_operand_2 !== b ||
          alu_bit_position !== bp || alu_immediate !== im || alu_rd !== rd) stable = 1'b0;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL op_timeout: opcode=%0d still busy after 40 cycles", opc);
    end
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL alu_hold: opcode=%0d alu_* outputs changed during op, required stable", opc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    drive_issue(5'd0, 3'd0, 16'd0, 16'd0, 4'd0, 8'd0);
    issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({issue_ready, busy, alu_en, wb_en, flag_reg_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/busy/alu_en/wb_en/flag_en=%b required 00000",
               {issue_ready, busy, alu_en, wb_en, flag_reg_en});
    end
    n_checks++;
    if ({alu_operand_1, alu_operand_2, wb_data, flag_data, alu_opcode, wb_addr} !== '0) begin
      n_fail++; $display("FAIL reset_data: data outputs not all zero, required 0");
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: issue_ready=%b required 1", issue_ready);
    end
  endtask

  task automatic test_add();
    int b_c, a_c, w_c, f_c;
    run_op(OP_ADD, 3'd2, 16'h7FFF, 16'h0001, 4'd0, 8'd0, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != 2 || a_c != 1 || w_c != 1 || f_c != 1) begin
      n_fail++; $display("FAIL add_timing: busy=%0d alu_en=%0d wb=%0d flag=%0d required 2 1 1 1", b_c, a_c, w_c, f_c);
    end
    n_checks++;
    if (last_wb_addr !== 3'd2 || last_wb_data !== 16'h8000) begin
      n_fail++; $display("FAIL add_result: addr=%0d data=%h required 2 8000", last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_mul_wrap();
    int b_c, a_c, w_c, f_c;
    run_op(OP_MUL, 3'd7, 16'h1234, 16'h0100, 4'd0, 8'd0, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != MUL_LAT + 2 || a_c != MUL_LAT || w_c != 2 || f_c != 1) begin
      n_fail++; $display("FAIL mul_timing: busy=%0d alu_en=%0d wb=%0d flag=%0d required 5 3 2 1", b_c, a_c, w_c, f_c);
    end
    n_checks++;
    if (last_wb_addr !== 3'd0 || last_wb_data !== 16'h0012) begin
      n_fail++; $display("FAIL mul_wb1: addr=%0d data=%h required 0 0012", last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_cmp();
    int b_c, a_c, w_c, f_c;
    run_op(OP_CMP, 3'd1, 16'd5, 16'd5, 4'd0, 8'd0, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != 2 || w_c != 0 || f_c != 1) begin
      n_fail++; $display("FAIL cmp_timing: busy=%0d wb=%0d flag=%0d required 2 0 1", b_c, w_c, f_c);
    end
    n_checks++;
    if (last_flag_data[3] !== 1'b1) begin
      n_fail++; $display("FAIL cmp_eq_flag: flag_data=%h required bit3=1", last_flag_data);
    end
  endtask

  task automatic test_move_lbh();
    int b_c, a_c, w_c, f_c;
    run_op(OP_LBH, 3'd3, 16'h00CD, 16'h0000, 4'd0, 8'hAB, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != 2 || a_c != 0 || w_c != 1 || f_c != 0) begin
      n_fail++; $display("FAIL lbh_timing: busy=%0d alu_en=%0d wb=%0d flag=%0d required 2 0 1 0", b_c, a_c, w_c, f_c);
    end
    n_checks++;
    if (last_wb_addr !== 3'd3 || last_wb_data !== 16'hABCD) begin
      n_fail++; $display("FAIL lbh_result: addr=%0d data=%h required 3 ABCD", last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_nop_and_div0();
    int b_c, a_c, w_c, f_c;
    run_op(5'd31, 3'd4, 16'h1111, 16'h2222, 4'd0, 8'd0, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != 1 || a_c != 0 || w_c != 0 || f_c != 0) begin
      n_fail++; $display("FAIL nop_timing: busy=%0d alu_en=%0d wb=%0d flag=%0d required 1 0 0 0", b_c, a_c, w_c, f_c);
    end
    run_op(OP_DIV, 3'd7, 16'h4321, 16'h0000, 4'd0, 8'd0, b_c, a_c, w_c, f_c);
    n_checks++;
    if (b_c != DIV_LAT + 2 || a_c != DIV_LAT || w_c != 2 || f_c != 1) begin
      n_fail++; $display("FAIL div_timing: busy=%0d alu_en=%0d wb=%0d flag=%0d required 10 8 2 1", b_c, a_c, w_c, f_c);
    end
    n_checks++;
    if (last_wb_addr !== 3'd0 || last_wb_data !== 16'h4321) begin
      n_fail++; $display("FAIL div0_wb1: addr=%0d data=%h required 0 4321", last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_mixed();
    logic [4:0] ops[7];
    int b_c, a_c, w_c, f_c, eb, ew;
    ops = '{OP_SUB, OP_XOR, OP_RL, OP_SETB, OP_SETF, OP_MOV, OP_LBL};
    foreach (ops[k]) begin
      run_op(ops[k], 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             4'($urandom_range(0, 15)), 8'($urandom), b_c, a_c, w_c, f_c);
      eb = 2;
      ew = no_wb_op(ops[k]) ? 0 : 1;
      n_checks++;
      if (b_c != eb || w_c != ew || a_c != int'(is_alu_op(ops[k])) || f_c != int'(is_alu_op(ops[k]))) begin
        n_fail++;
        $display("FAIL mixed_timing: opcode=%0d busy=%0d alu_en=%0d wb=%0d flag=%0d required %0d %0d %0d %0d",
                 ops[k], b_c, a_c, w_c, f_c, eb, int'(is_alu_op(ops[k])), ew, int'(is_alu_op(ops[k])));
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_issue(OP_DIV, 3'd2, 16'd100, 16'd7, 4'd0, 8'd0);
    @(negedge clk);
    drive_issue(OP_ADD, 3'd5, 16'd3, 16'd4, 4'd0, 8'd0);
    push_expect(OP_ADD, 3'd5, 16'd3, 16'd4, 4'd0, 8'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || alu_en !== 1'b1 || alu_opcode !== OP_DIV) begin
      n_fail++; $display("FAIL flush_exec: busy=%b alu_en=%b opcode=%0d required 1 1 4", busy, alu_en, alu_opcode);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || issue_ready !== 1'b1 || wb_en !== 1'b0 || flag_reg_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: busy=%b ready=%b wb_en=%b flag_en=%b required 0 1 0 0",
                         busy, issue_ready, wb_en, flag_reg_en);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || alu_en !== 1'b1 || alu_opcode !== OP_ADD) begin
      n_fail++; $display("FAIL flush_next_accept: busy=%b alu_en=%b opcode=%0d required 1 1 1", busy, alu_en, alu_opcode);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || last_wb_addr !== 3'd5 || last_wb_data !== 16'd7) begin
      n_fail++; $display("FAIL flush_follow_wb: busy=%b addr=%0d data=%h required 0 5 0007", busy, last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    drive_issue(OP_MUL, 3'd7, 16'h1234, 16'h0100, 4'd0, 8'd0);
    exp_wb.push_back({3'd7, 16'h3400});
    exp_flg.push_back(alu_model(OP_MUL, 16'h1234, 16'h0100, 4'd0, 8'd0) >> 0);
    @(negedge clk);
    drive_issue(OP_INC, 3'd4, 16'd9, 16'd0, 4'd0, 8'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b1 || flag_reg_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_wb0: wb_en=%b flag_en=%b required 1 1", wb_en, flag_reg_en);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({issue_ready, busy, wb_en, flag_reg_en, alu_en} !== 5'b0 ||
        {wb_data, alu_operand_1, alu_opcode, flag_data} !== '0) begin
      n_fail++; $display("FAIL rst_async: outputs not zero immediately after reset assertion, required 0");
    end
    push_expect(OP_INC, 3'd4, 16'd9, 16'd0, 4'd0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || alu_en !== 1'b1 || alu_opcode !== OP_INC) begin
      n_fail++; $display("FAIL rst_first_accept: busy=%b alu_en=%b opcode=%0d required 1 1 9", busy, alu_en, alu_opcode);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (last_wb_addr !== 3'd4 || last_wb_data !== 16'd10) begin
      n_fail++; $display("FAIL rst_follow_wb: addr=%0d data=%h required 4 000A", last_wb_addr, last_wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_wrap();
    test_cmp();
    test_move_lbh();
    test_nop_and_div0();
    test_mixed();
    test_flush();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_wb.size() != 0 || exp_flg.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d writes and %0d flag loads never seen, required 0 0",
                         exp_wb.size(), exp_flg.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
